// File: rtl/digit_entry_if.sv
// Signal bundle between the raw board inputs (KEY[0], SW[3:0]) and the
// debounced digit strobes consumed by the lock FSM and display decoder.
interface digit_entry_if;
  logic       key_n;
  logic [3:0] sw;
  logic [3:0] digit;
  logic       digit_valid;
  logic       digit_bad;
  logic [2:0] entry_count;
  logic       key_stable;

  // master: the side that owns the raw button/switches and consumes strobes
  modport master (
    output key_n,
    output sw,
    input  digit,
    input  digit_valid,
    input  digit_bad,
    input  entry_count,
    input  key_stable
  );

  // slave: the digit_entry block itself
  modport slave (
    input  key_n,
    input  sw,
    output digit,
    output digit_valid,
    output digit_bad,
    output entry_count,
    output key_stable
  );
endinterface

// File: rtl/digit_entry.sv
// Synchronises and debounces the entry button, then issues one registered
// digit strobe (with the captured switch value) per accepted press.
module digit_entry #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 20
) (
  input logic          clk,
  input logic          rst_n,
  digit_entry_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [2:0]       ENTRY_MAX = 3'd6;

  logic [1:0]       key_sync_reg;
  logic             key_s;
  logic [3:0]       sw_s;

  state_t           state_reg;
  state_t           state_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic             accept;

  logic [3:0]       digit_reg;
  logic             digit_valid_reg;
  logic             digit_bad_reg;
  logic [2:0]       entry_count_reg;
  logic             key_stable_reg;

  // Key chain resets to "released" so reset never fakes a press edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_sync_reg <= 2'b11;
    end else begin
      key_sync_reg <= {key_sync_reg[0], bus.key_n};
    end
  end

  assign key_s = key_sync_reg[1];

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_sw_sync
      logic [1:0] sync_reg;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sync_reg <= 2'b00;
        end else begin
          sync_reg <= {sync_reg[0], bus.sw[gi]};
        end
      end

      assign sw_s[gi] = sync_reg[1];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Any opposite-level sample in a wait state abandons qualification.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    accept     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!key_s) begin
          state_next = PRESS_WAIT;
          cnt_next   = '0;
        end
      end
      PRESS_WAIT: begin
        if (key_s) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (cnt_reg == CNT_LAST) begin
          state_next = PRESSED;
          cnt_next   = '0;
          accept     = 1'b1;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      PRESSED: begin
        if (key_s) begin
          state_next = RELEASE_WAIT;
          cnt_next   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (!key_s) begin
          state_next = PRESSED;
          cnt_next   = '0;
        end else if (cnt_reg == CNT_LAST) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Decoding state_next keeps key_stable aligned with the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_reg       <= 4'd0;
      digit_valid_reg <= 1'b0;
      digit_bad_reg   <= 1'b0;
      entry_count_reg <= 3'd0;
      key_stable_reg  <= 1'b0;
    end else begin
      digit_valid_reg <= accept;
      key_stable_reg  <= (state_next == PRESSED) || (state_next == RELEASE_WAIT);
      if (accept) begin
        digit_reg     <= sw_s;
        digit_bad_reg <= (sw_s > 4'd9);
        if (entry_count_reg != ENTRY_MAX) begin
          entry_count_reg <= entry_count_reg + 3'd1;
        end
      end
    end
  end

  assign bus.digit       = digit_reg;
  assign bus.digit_valid = digit_valid_reg;
  assign bus.digit_bad   = digit_bad_reg;
  assign bus.entry_count = entry_count_reg;
  assign bus.key_stable  = key_stable_reg;

endmodule
